// File: rtl/int_seq.sv
// Interrupt/BRK/reset entry sequencer: arbitrates sources at instruction
// boundaries and steps the 7-cycle entry sequence that qualifies the decoder.
module int_seq #(
    parameter logic [15:0] NMI_VEC = 16'hFFFA,
    parameter logic [15:0] RST_VEC = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        READY,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        i_sync,
    input  logic        i_brk,
    input  logic        i_flag_i,
    output logic        o_active,
    output logic [2:0]  o_step,
    output logic [1:0]  o_src,
    output logic        o_force_brk,
    output logic        o_inhibit_ipc,
    output logic        o_push,
    output logic        o_stack_dec,
    output logic        o_b_flag,
    output logic        o_vec_fetch,
    output logic [15:0] o_vec_addr,
    output logic        o_set_i,
    output logic        o_done
);

    localparam logic [1:0] SRC_BRK = 2'd0;
    localparam logic [1:0] SRC_IRQ = 2'd1;
    localparam logic [1:0] SRC_NMI = 2'd2;
    localparam logic [1:0] SRC_RST = 2'd3;

    logic       active_q, active_d;
    logic [2:0] step_q, step_d;
    logic [1:0] src_q, src_d;
    logic       nmi_latch_q, nmi_latch_d;
    logic       nmi_prev_q, nmi_prev_d;
    logic       nmi_fall;
    logic [15:0] vec_base;

    assign nmi_fall = ~NMI & nmi_prev_q;

    always_comb begin
        active_d    = active_q;
        step_d      = step_q;
        src_d       = src_q;
        nmi_latch_d = nmi_latch_q;
        nmi_prev_d  = nmi_prev_q;
        if (READY) begin
            nmi_prev_d = NMI;
            if (active_q) begin
                if (step_q == 3'd6) begin
                    active_d = 1'b0;
                    step_d   = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
                // Late NMI hijacks a BRK/IRQ entry before the vector fetch
                if (step_q == 3'd4 && (src_q == SRC_BRK || src_q == SRC_IRQ) && nmi_latch_q)
                    src_d = SRC_NMI;
                if (step_q == 3'd5 && src_q == SRC_NMI)
                    nmi_latch_d = 1'b0;
            end else if (i_sync) begin
                if (nmi_latch_q) begin
                    active_d = 1'b1;
                    step_d   = 3'd0;
                    src_d    = SRC_NMI;
                end else if (!IRQ && !i_flag_i) begin
                    active_d = 1'b1;
                    step_d   = 3'd0;
                    src_d    = SRC_IRQ;
                end else if (i_brk) begin
                    active_d = 1'b1;
                    step_d   = 3'd0;
                    src_d    = SRC_BRK;
                end
            end
            // A fresh falling edge overrides the clear in the same cycle
            if (nmi_fall)
                nmi_latch_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q    <= 1'b1;
            step_q      <= 3'd0;
            src_q       <= SRC_RST;
            nmi_latch_q <= 1'b0;
            nmi_prev_q  <= 1'b1;
        end else begin
            active_q    <= active_d;
            step_q      <= step_d;
            src_q       <= src_d;
            nmi_latch_q <= nmi_latch_d;
            nmi_prev_q  <= nmi_prev_d;
        end
    end

    always_comb begin
        case (src_q)
            SRC_NMI: vec_base = NMI_VEC;
            SRC_RST: vec_base = RST_VEC;
            default: vec_base = IRQ_VEC;
        endcase
    end

    always_comb begin
        o_force_brk   = 1'b0;
        o_inhibit_ipc = 1'b0;
        o_push        = 1'b0;
        o_stack_dec   = 1'b0;
        o_b_flag      = 1'b0;
        o_vec_fetch   = 1'b0;
        o_set_i       = 1'b0;
        o_done        = 1'b0;
        o_vec_addr    = vec_base;
        if (active_q) begin
            case (step_q)
                3'd0: begin
                    o_force_brk   = (src_q != SRC_BRK);
                    o_inhibit_ipc = (src_q != SRC_BRK);
                end
                3'd1: o_inhibit_ipc = (src_q != SRC_BRK);
                3'd2, 3'd3: begin
                    o_stack_dec = 1'b1;
                    o_push      = (src_q != SRC_RST);
                end
                3'd4: begin
                    o_stack_dec = 1'b1;
                    o_push      = (src_q != SRC_RST);
                    o_b_flag    = (src_q == SRC_BRK);
                end
                3'd5: o_vec_fetch = 1'b1;
                3'd6: begin
                    o_vec_fetch = 1'b1;
                    o_vec_addr  = vec_base | 16'h0001;
                    o_set_i     = 1'b1;
                    o_done      = READY;
                end
                default: ;
            endcase
        end
    end

    assign o_active = active_q;
    assign o_step   = step_q;
    assign o_src    = src_q;

endmodule

// File: tb/tb_int_seq.sv
// Directed table-driven bench for int_seq plus hand-written corner sequences.
module tb_int_seq;

    logic        clk = 1'b0;
    logic        rst_n, ready, nmi, irq, sync, brk, fi;
    logic        o_active, o_force_brk, o_inhibit_ipc, o_push, o_stack_dec;
    logic        o_b_flag, o_vec_fetch, o_set_i, o_done;
    logic [2:0]  o_step;
    logic [1:0]  o_src;
    logic [15:0] o_vec_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy, nmi, irq, sync, brk, fi;
        logic [29:0] exp;
    } vec_t;

    vec_t tbl[$];

    int_seq #(.NMI_VEC(16'hFFFA), .RST_VEC(16'hFFFC), .IRQ_VEC(16'hFFFE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .READY(ready), .NMI(nmi), .IRQ(irq),
        .i_sync(sync), .i_brk(brk), .i_flag_i(fi),
        .o_active(o_active), .o_step(o_step), .o_src(o_src),
        .o_force_brk(o_force_brk), .o_inhibit_ipc(o_inhibit_ipc),
        .o_push(o_push), .o_stack_dec(o_stack_dec), .o_b_flag(o_b_flag),
        .o_vec_fetch(o_vec_fetch), .o_vec_addr(o_vec_addr),
        .o_set_i(o_set_i), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // flags: {force_brk, inhibit_ipc, push, stack_dec, b_flag, vec_fetch, set_i, done}
    function automatic logic [29:0] E(input logic act, input int stp, input int src,
                                      input logic [7:0] fl, input logic [15:0] va);
        return {act, 3'(stp), 2'(src), fl, va};
    endfunction

    function automatic vec_t V(input logic r, n, q, s, b, f, input logic [29:0] e);
        vec_t v;
        v.rdy = r; v.nmi = n; v.irq = q; v.sync = s; v.brk = b; v.fi = f; v.exp = e;
        return v;
    endfunction

    function automatic logic [29:0] actual();
        return {o_active, o_step, o_src, o_force_brk, o_inhibit_ipc, o_push, o_stack_dec,
                o_b_flag, o_vec_fetch, o_set_i, o_done, o_vec_addr};
    endfunction

    task automatic check(input string name, input logic [29:0] exp);
        logic [29:0] a;
        a = actual();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, a, exp);
        end
    endtask

    task automatic drive(input logic r, rd, n, q, s, b, f);
        @(negedge clk);
        rst_n = r; ready = rd; nmi = n; irq = q; sync = s; brk = b; fi = f;
        #1;
    endtask

    logic [7:0]  rflags [7];
    logic [15:0] rvec   [7];
    int          sstep  [10];
    int          act_cnt;

    initial begin
        rflags = '{8'b1100_0000, 8'b0100_0000, 8'b0001_0000, 8'b0001_0000,
                   8'b0001_0000, 8'b0000_0100, 8'b0000_0111};
        rvec   = '{16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFD};
        sstep  = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6};

        // Reset release, src=RESET: reads not pushes on steps 2-4
        for (int i = 0; i < 7; i++)
            tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, i, 3, rflags[i], rvec[i])));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(0, 0, 3, 8'h00, 16'hFFFC)));
        // Boundary with READY=0 must not start
        tbl.push_back(V(0, 1, 0, 1, 0, 0, E(0, 0, 3, 8'h00, 16'hFFFC)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(0, 0, 3, 8'h00, 16'hFFFC)));
        // IRQ entry
        tbl.push_back(V(1, 1, 0, 1, 0, 0, E(0, 0, 3, 8'h00, 16'hFFFC)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(1, 0, 1, 8'b1100_0000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(1, 1, 1, 8'b0100_0000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(1, 2, 1, 8'b0011_0000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(1, 3, 1, 8'b0011_0000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(1, 4, 1, 8'b0011_0000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(1, 5, 1, 8'b0000_0100, 16'hFFFE)));
        tbl.push_back(V(1, 1, 0, 0, 0, 0, E(1, 6, 1, 8'b0000_0111, 16'hFFFF)));
        // IRQ masked by I flag; then BRK entry
        tbl.push_back(V(1, 1, 0, 1, 0, 1, E(0, 0, 1, 8'h00, 16'hFFFE)));
        tbl.push_back(V(1, 1, 1, 1, 1, 1, E(0, 0, 1, 8'h00, 16'hFFFE)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, 0, 0, 8'h00, 16'hFFFE)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, 1, 0, 8'h00, 16'hFFFE)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, 2, 0, 8'b0011_0000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, 3, 0, 8'b0011_0000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, 4, 0, 8'b0011_1000, 16'hFFFE)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, 5, 0, 8'b0000_0100, 16'hFFFE)));
        tbl.push_back(V(0, 1, 1, 0, 0, 1, E(1, 6, 0, 8'b0000_0110, 16'hFFFF)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(1, 6, 0, 8'b0000_0111, 16'hFFFF)));
        tbl.push_back(V(1, 1, 1, 0, 0, 1, E(0, 0, 0, 8'h00, 16'hFFFE)));

        rst_n = 1'b0; ready = 1'b1; nmi = 1'b1; irq = 1'b1; sync = 1'b0; brk = 1'b0; fi = 1'b1;
        drive(0, 1, 1, 1, 0, 0, 1);
        check("reset_state", E(1, 0, 3, 8'b1100_0000, 16'hFFFC));
        drive(0, 1, 1, 1, 1, 1, 1);
        check("reset_held", E(1, 0, 3, 8'b1100_0000, 16'hFFFC));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(1, tbl[i].rdy, tbl[i].nmi, tbl[i].irq, tbl[i].sync, tbl[i].brk, tbl[i].fi);
            check($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // BRK hijacked by NMI falling at step 2
        drive(1, 1, 1, 1, 1, 1, 1); check("hj_idle", E(0, 0, 0, 8'h00, 16'hFFFE));
        drive(1, 1, 1, 1, 0, 0, 1); check("hj_s0", E(1, 0, 0, 8'h00, 16'hFFFE));
        drive(1, 1, 1, 1, 0, 0, 1); check("hj_s1", E(1, 1, 0, 8'h00, 16'hFFFE));
        drive(1, 1, 0, 1, 0, 0, 1); check("hj_s2", E(1, 2, 0, 8'b0011_0000, 16'hFFFE));
        drive(1, 1, 0, 1, 0, 0, 1); check("hj_s3", E(1, 3, 0, 8'b0011_0000, 16'hFFFE));
        drive(1, 1, 0, 1, 0, 0, 1); check("hj_s4_bflag", E(1, 4, 0, 8'b0011_1000, 16'hFFFE));
        drive(1, 1, 0, 1, 0, 0, 1); check("hj_s5_nmivec", E(1, 5, 2, 8'b0000_0100, 16'hFFFA));
        drive(1, 1, 0, 1, 0, 0, 1); check("hj_s6", E(1, 6, 2, 8'b0000_0111, 16'hFFFB));
        drive(1, 1, 0, 1, 1, 0, 1); check("hj_end", E(0, 0, 2, 8'h00, 16'hFFFA));
        drive(1, 1, 0, 1, 0, 0, 1); check("hj_nostart", E(0, 0, 2, 8'h00, 16'hFFFA));

        // NMI held low: one sequence only, with a 3-cycle READY stall at step 3
        drive(1, 1, 1, 1, 0, 0, 1); check("hold_pre", E(0, 0, 2, 8'h00, 16'hFFFA));
        drive(1, 1, 0, 1, 0, 0, 1); check("hold_fall", E(0, 0, 2, 8'h00, 16'hFFFA));
        drive(1, 1, 0, 1, 1, 0, 1); check("hold_bnd", E(0, 0, 2, 8'h00, 16'hFFFA));
        act_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, !(i >= 3 && i <= 5), 0, 1, 1, 0, 1);
            if (o_active) act_cnt++;
            checks++;
            if ({o_active, o_step, o_src} !== {1'b1, 3'(sstep[i]), 2'd2}) begin
                errors++;
                $display("FAIL hold_step%0d got %b/%0d/%0d want 1/%0d/2", i, o_active, o_step, o_src, sstep[i]);
            end
            if (i == 3) check("hold_stall", E(1, 3, 2, 8'b0011_0000, 16'hFFFA));
            if (i == 8) check("hold_vec", E(1, 5, 2, 8'b0000_0100, 16'hFFFA));
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 1, 1, 0, 1);
            if (o_active) act_cnt++;
        end
        checks++;
        if (act_cnt != 10) begin
            errors++;
            $display("FAIL hold_duration got %0d want 10", act_cnt);
        end

        // NMI and IRQ pending together, then reset mid-IRQ with an NMI pending
        drive(1, 1, 1, 1, 0, 0, 1); check("pri_pre", E(0, 0, 2, 8'h00, 16'hFFFA));
        drive(1, 1, 0, 0, 0, 0, 0); check("pri_fall", E(0, 0, 2, 8'h00, 16'hFFFA));
        drive(1, 1, 0, 0, 1, 0, 0); check("pri_bnd", E(0, 0, 2, 8'h00, 16'hFFFA));
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            checks++;
            if ({o_active, o_step, o_src} !== {1'b1, 3'(i), 2'd2}) begin
                errors++;
                $display("FAIL pri_nmi%0d got %b/%0d/%0d want 1/%0d/2", i, o_active, o_step, o_src, i);
            end
        end
        drive(1, 1, 0, 0, 1, 0, 0); check("pri_bnd2", E(0, 0, 2, 8'h00, 16'hFFFA));
        drive(1, 1, 1, 0, 0, 0, 0); check("pri_irq_s0", E(1, 0, 1, 8'b1100_0000, 16'hFFFE));
        drive(1, 1, 0, 0, 0, 0, 0); check("pri_irq_s1", E(1, 1, 1, 8'b0100_0000, 16'hFFFE));
        drive(1, 1, 1, 0, 0, 0, 0); check("pri_irq_s2", E(1, 2, 1, 8'b0011_0000, 16'hFFFE));
        drive(1, 1, 1, 0, 0, 0, 0); check("pri_irq_s3", E(1, 3, 1, 8'b0011_0000, 16'hFFFE));
        drive(1, 1, 1, 0, 0, 0, 0); check("pri_irq_s4", E(1, 4, 1, 8'b0011_0000, 16'hFFFE));
        #1 rst_n = 1'b0;
        #1 check("midseq_reset", E(1, 0, 3, 8'b1100_0000, 16'hFFFC));
        drive(0, 1, 1, 1, 0, 0, 1); check("midseq_held", E(1, 0, 3, 8'b1100_0000, 16'hFFFC));
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 1, 1, 0, 0, 1);
            check($sformatf("rst2_s%0d", i), E(1, i, 3, rflags[i], rvec[i]));
        end
        drive(1, 1, 1, 1, 1, 0, 1); check("rst2_end", E(0, 0, 3, 8'h00, 16'hFFFC));
        drive(1, 1, 1, 1, 0, 0, 1); check("nmi_discarded", E(0, 0, 3, 8'h00, 16'hFFFC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
